// File: rtl/mcpu_alu_mc_if.sv
// mcpu_alu_mc_if: request/response bundle for the multi-cycle MCPU ALU.
//   Request side : in_valid, in_ready, opcode, r1, r2
//   Response side: out_valid, out_ready, out, OVERFLOW, zero, illegal
//   master modport = producer/consumer (register-file read / write-back)
//   slave  modport = the ALU itself
interface mcpu_alu_mc_if #(
  parameter int CMD_SIZE  = 3,
  parameter int WORD_SIZE = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [CMD_SIZE-1:0]  opcode;
  logic [WORD_SIZE-1:0] r1;
  logic [WORD_SIZE-1:0] r2;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out;
  logic                 OVERFLOW;
  logic                 zero;
  logic                 illegal;

  modport master (
    output in_valid, opcode, r1, r2, out_ready,
    input  in_ready, out_valid, out, OVERFLOW, zero, illegal
  );

  modport slave (
    input  in_valid, opcode, r1, r2, out_ready,
    output in_ready, out_valid, out, OVERFLOW, zero, illegal
  );
endinterface

// File: rtl/mcpu_alu_mc.sv
// mcpu_alu_mc: multi-cycle handshaked ALU (AND/OR/XOR/ADD/SUB/SHL/SHR/MUL).
//   clk   : single rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mcpu_alu_mc_if.slave (valid/ready request in, valid/ready result out)
// Optional feature macro: MCPU_ALU_MUL_EN -- when defined, opcode 111 runs an
// iterative shift-add multiplier; when undefined, 111 is flagged illegal and
// takes the normal single-step path.
// Result path: EXEC (or the last MUL step) writes a result register, and the
// output register stage loads it on the first DONE cycle, so out_valid rises
// two edges after accept (WORD_SIZE+1 for MUL).
module mcpu_alu_mc #(
  parameter int CMD_SIZE  = 3,
  parameter int WORD_SIZE = 8
) (
  input logic           clk,
  input logic           rst_n,
  mcpu_alu_mc_if.slave  bus
);
  localparam int W = WORD_SIZE;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  state_t       state, state_nxt;
  req_t         req;
  logic [W-1:0] res_q, alu_res;
  logic         ovf_q, ill_q, alu_ovf, alu_ill;
  logic [2*W-1:0] shl_full;
  logic         shamt_big;
  logic         accept;

  assign accept       = (state == IDLE) && bus.in_valid;
  assign bus.in_ready = (state == IDLE);

`ifdef MCPU_ALU_MUL_EN
  localparam int CW = $clog2(WORD_SIZE + 1);
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc, acc_nxt, mcnd;
  logic [W-1:0]   mplr;
  logic           mul_last;

  assign acc_nxt  = mplr[0] ? acc + mcnd : acc;
  assign mul_last = (cnt == CW'(WORD_SIZE - 1));

  // One multiplier bit per cycle, LSB first; multiplicand shifts up to match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      acc  <= '0;
      mcnd <= '0;
      mplr <= '0;
    end else if (accept) begin
      cnt  <= '0;
      acc  <= '0;
      mcnd <= {{W{1'b0}}, bus.r1};
      mplr <= bus.r2;
    end else if (state == MUL) begin
      acc  <= acc_nxt;
      mcnd <= mcnd << 1;
      mplr <= mplr >> 1;
      cnt  <= mul_last ? '0 : cnt + 1'b1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) begin
`ifdef MCPU_ALU_MUL_EN
        state_nxt = (bus.opcode[2:0] == 3'b111) ? MUL : EXEC;
`else
        state_nxt = EXEC;
`endif
      end
      EXEC: state_nxt = DONE;
`ifdef MCPU_ALU_MUL_EN
      MUL:  if (mul_last) state_nxt = DONE;
`else
      MUL:  state_nxt = DONE;
`endif
      DONE: if (bus.out_valid && bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-step datapath on latched operands
  always_comb begin
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    shl_full  = {{W{1'b0}}, req.a} << req.b;
    shamt_big = (req.b >= W'(WORD_SIZE));
    case (req.op)
      3'b000: alu_res = req.a & req.b;
      3'b001: alu_res = req.a | req.b;
      3'b010: alu_res = req.a ^ req.b;
      3'b011: begin
        alu_res = req.a + req.b;
        alu_ovf = (req.a[W-1] == req.b[W-1]) && (alu_res[W-1] != req.a[W-1]);
      end
      3'b100: begin
        alu_res = req.a - req.b;
        alu_ovf = (req.a[W-1] != req.b[W-1]) && (alu_res[W-1] != req.a[W-1]);
      end
      3'b101: begin
        // Oversized shifts drop every bit, so overflow is just "anything set".
        alu_res = shamt_big ? '0 : shl_full[W-1:0];
        alu_ovf = shamt_big ? |req.a : |shl_full[2*W-1:W];
      end
      3'b110: alu_res = shamt_big ? '0 : req.a >> req.b;
      default: begin
`ifndef MCPU_ALU_MUL_EN
        alu_ill = 1'b1;
`endif
      end
    endcase
  end

  // Operand latch and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req   <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      if (accept) req <= '{op: bus.opcode[2:0], a: bus.r1, b: bus.r2};
      if (state == EXEC) begin
        res_q <= alu_res;
        ovf_q <= alu_ovf;
        ill_q <= alu_ill;
      end
`ifdef MCPU_ALU_MUL_EN
      else if (state == MUL && mul_last) begin
        res_q <= acc_nxt[W-1:0];
        ovf_q <= |acc_nxt[2*W-1:W];
        ill_q <= 1'b0;
      end
`endif
    end
  end

  // Output stage: loads once on DONE entry, then holds until handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.OVERFLOW  <= 1'b0;
      bus.zero      <= 1'b0;
      bus.illegal   <= 1'b0;
    end else if (state == DONE && !bus.out_valid) begin
      bus.out_valid <= 1'b1;
      bus.out       <= res_q;
      bus.OVERFLOW  <= ovf_q;
      bus.zero      <= (res_q == '0);
      bus.illegal   <= ill_q;
    end else if (state == DONE && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule
